popcount16_unary_gen: RTL and testbench
=======================================

POPCOUNT16_UNARY_GEN -- requirements
Module: popcount16_unary_gen

Interface
REQ-001 Parameter: ROT_EN, default 1, 1 = rotate ones placement per accepted word, 0 = ones always LSB-aligned.
REQ-002 Parameter: FIFO_DEPTH, default 2, output buffer entries; legal values 2 only.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  count on input_a valid.
REQ-006 in_ready  output  1  block can accept a count this cycle.
REQ-007 input_a  input  5  requested ones count k, 0..31.
REQ-008 rot_clr  input  1  synchronous clear of rotation offset.
REQ-009 out_valid  output  1  head word valid.
REQ-010 out_ready  input  1  consumer takes head word this cycle.
REQ-011 popcount16_unary_gen_out  output  16  generated word; exactly min(k,16) bits set.
REQ-012 out_sat  output  1  head word came from k > 16.
REQ-013 words_acc  output  16  count of accepted inputs, wraps 0xFFFF -> 0x0000.

Function
REQ-014 Accept occurs when in_valid && in_ready; transfer occurs when out_valid && out_ready.
REQ-015 in_ready SHALL be 1 when the buffer holds fewer than FIFO_DEPTH entries, independent of out_ready (no combinational ready path).
REQ-016 On accept, kc = min(k,16), sat = (k > 16); word = rotate-left of thermometer(kc) (bits kc-1..0 set) by current rot.
REQ-017 rot is a 4-bit offset, reset 0; with ROT_EN=1 it increments by 1 mod 16 on each accept; with ROT_EN=0 it stays 0.
REQ-018 The accepted word uses rot as it was before the edge; rot_clr in the same cycle forces rot to 0 (clear wins over increment).
REQ-019 Word and sat are written into a FIFO_DEPTH-entry FIFO; head drives popcount16_unary_gen_out/out_sat.
REQ-020 Latency: word accepted at edge N into an empty buffer is visible with out_valid=1 after edge N (one cycle).
REQ-021 Simultaneous accept and transfer while full is not possible (in_ready=0); while partially full, both occur and occupancy is unchanged.
REQ-022 While out_valid && !out_ready, head word and out_sat SHALL remain stable.
REQ-023 When out_valid=0, popcount16_unary_gen_out = 0x0000 and out_sat = 0.
REQ-024 words_acc increments by 1 per accept, wraps modulo 2^16.
REQ-025 Order preserved: words leave in acceptance order, no drop, no duplication.

Reset
REQ-026 rst_n low SHALL asynchronously clear FIFO occupancy, pointers, rot, words_acc; out_valid=0, in_ready=1 during and after reset.
REQ-027 Reset mid-operation discards all buffered words; first word after release uses rot=0.
REQ-028 Outputs reset values: out_valid 0, popcount16_unary_gen_out 0x0000, out_sat 0, words_acc 0x0000.

Structure
REQ-029 Shared package popcount16_pkg SHALL hold VEC_W=16, CNT_W=5, CNT_MAX=16, ROT_W=4 and the thermometer/rotate helper function.
REQ-030 One sub-module popcount16_unary_fifo (2-entry, 17-bit payload: word + sat, full/empty flags); generator logic stays in the top.

Verification
REQ-031 After reset, k=0 then k=3, out_ready=1, ROT_EN=1 -> words 0x0000 (rot 0), 0x000E (rot 1); out_sat 0,0.
REQ-032 rot at 14, k=4 -> 0xC003; following k=1 (rot 15) -> 0x8000; next k=1 -> 0x0001 (wrap to 0).
REQ-033 k=20 -> 0xFFFF, out_sat=1; k=16 at any rot -> 0xFFFF, out_sat=0.
REQ-034 out_ready=0, send k=1,2,3 back-to-back -> in_ready drops after second accept, third held; release -> 0x0001, 0x0006(rot1), 0x001C(rot2) in order, head stable while stalled.
REQ-035 rot_clr with accept at rot=7, k=2 -> word 0x0180, next k=2 -> 0x0003.
REQ-036 rst_n low with 2 words buffered -> out_valid 0 immediately, words_acc 0, next k=5 -> 0x001F; random k with popcount checker on every output word.

Source files
------------

// File: rtl/popcount16_pkg.sv
// Shared constants, FIFO payload type and the thermometer/rotate helper
// used by the unary word generator.
package popcount16_pkg;

    localparam int VEC_W   = 16;
    localparam int CNT_W   = 5;
    localparam int CNT_MAX = 16;
    localparam int ROT_W   = 4;

    typedef struct packed {
        logic             sat;
        logic [VEC_W-1:0] word;
    } pc_entry_t;

    // kc low bits set, then rotated left by rot; kc >= CNT_MAX gives all ones.
    function automatic logic [VEC_W-1:0] therm_rot(
        input logic [CNT_W-1:0] kc,
        input logic [ROT_W-1:0] rot
    );
        logic [VEC_W-1:0]   therm;
        logic [2*VEC_W-1:0] dbl;
        if (kc >= CNT_W'(CNT_MAX))
            therm = '1;
        else
            therm = (VEC_W'(1) << kc) - VEC_W'(1);
        dbl = {therm, therm} << rot;
        return dbl[2*VEC_W-1:VEC_W];
    endfunction

endpackage

// File: rtl/popcount16_unary_fifo.sv
// Two-entry output buffer for generated words; head reads as zero when empty.
module popcount16_unary_fifo
    import popcount16_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      i_push,
    input  pc_entry_t i_wr_data,
    input  logic      i_pop,
    output pc_entry_t o_rd_data,
    output logic      o_full,
    output logic      o_empty,
    output logic [1:0] o_count
);

    pc_entry_t  r_mem [0:1];
    logic       r_wptr;
    logic       r_rptr;
    logic [1:0] r_count;

    logic w_push;
    logic w_pop;

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push)
                r_wptr <= ~r_wptr;
            if (w_pop)
                r_rptr <= ~r_rptr;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wptr] <= i_wr_data;
    end

    assign o_full    = (r_count == 2'(DEPTH));
    assign o_empty   = (r_count == 2'd0);
    assign o_count   = r_count;
    assign o_rd_data = o_empty ? '0 : r_mem[r_rptr];

endmodule

// File: rtl/popcount16_unary_gen.sv
// Turns a ones count k into a 16-bit word with min(k,16) bits set, optionally
// rotating placement per accepted word, and buffers results in a small FIFO.
module popcount16_unary_gen
    import popcount16_pkg::*;
#(
    parameter bit ROT_EN     = 1'b1,
    parameter int FIFO_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CNT_W-1:0] input_a,
    input  logic             rot_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [VEC_W-1:0] popcount16_unary_gen_out,
    output logic             out_sat,
    output logic [15:0]      words_acc
);

    logic [ROT_W-1:0] r_rot;
    logic [15:0]      r_words_acc;

    logic             w_accept;
    logic             w_sat;
    logic [CNT_W-1:0] w_kc;
    pc_entry_t        w_entry;
    pc_entry_t        w_head;
    logic             w_full;
    logic             w_empty;
    logic [1:0]       w_count;

    assign in_ready = (w_count < 2'(FIFO_DEPTH));
    assign w_accept = in_valid && in_ready;

    assign w_sat        = (input_a > CNT_W'(CNT_MAX));
    assign w_kc         = w_sat ? CNT_W'(CNT_MAX) : input_a;
    assign w_entry.sat  = w_sat;
    assign w_entry.word = therm_rot(w_kc, r_rot);

    // Clear beats increment; the accepted word already used the old offset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rot       <= '0;
            r_words_acc <= '0;
        end else begin
            if (rot_clr)
                r_rot <= '0;
            else if (w_accept && ROT_EN)
                r_rot <= r_rot + ROT_W'(1);
            if (w_accept)
                r_words_acc <= r_words_acc + 16'd1;
        end
    end

    popcount16_unary_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_push    (w_accept),
        .i_wr_data (w_entry),
        .i_pop     (out_ready),
        .o_rd_data (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_count   (w_count)
    );

    assign out_valid                = !w_empty;
    assign popcount16_unary_gen_out = w_head.word;
    assign out_sat                  = w_head.sat;
    assign words_acc                = r_words_acc;

    logic w_unused;
    assign w_unused = w_full;

endmodule

// File: tb/tb_popcount16_unary_gen.sv
// Scenario tasks plus a negedge scoreboard monitor for popcount16_unary_gen.
module tb_popcount16_unary_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        rot_clr = 1'b0;
    logic        out_ready = 1'b0;
    logic [4:0]  input_a = 5'd0;
    logic        in_ready;
    logic        out_valid;
    logic        out_sat;
    logic [15:0] dout;
    logic [15:0] words_acc;

    always #5 clk = ~clk;

    popcount16_unary_gen dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .in_valid                 (in_valid),
        .in_ready                 (in_ready),
        .input_a                  (input_a),
        .rot_clr                  (rot_clr),
        .out_valid                (out_valid),
        .out_ready                (out_ready),
        .popcount16_unary_gen_out (dout),
        .out_sat                  (out_sat),
        .words_acc                (words_acc)
    );

    typedef struct {
        logic [15:0] word;
        logic        sat;
        int          kc;
    } exp_t;

    exp_t        sb[$];
    exp_t        m_e;
    int          errors = 0;
    int          checks = 0;
    int          m_rot = 0;
    int          m_kc;
    logic [15:0] m_acc = '0;
    logic        stall_q = 1'b0;
    logic [15:0] stall_word;
    logic        stall_sat;

    function automatic logic [15:0] model_word(input int k, input int rot);
        logic [15:0] w;
        int          kc;
        w  = '0;
        kc = (k > 16) ? 16 : k;
        for (int i = 0; i < kc; i++)
            w[(rot + i) % 16] = 1'b1;
        return w;
    endfunction

    // Reference model and scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            m_rot   = 0;
            m_acc   = '0;
            stall_q = 1'b0;
        end else begin
            checks++;
            if (words_acc !== m_acc) begin
                errors++;
                $display("FAIL mon_words_acc: got %h want %h", words_acc, m_acc);
            end
            checks++;
            if (in_ready !== (sb.size() < 2)) begin
                errors++;
                $display("FAIL mon_in_ready: got %b want %b (occ %0d)", in_ready, sb.size() < 2, sb.size());
            end
            if (stall_q) begin
                checks++;
                if (out_valid !== 1'b1 || dout !== stall_word || out_sat !== stall_sat) begin
                    errors++;
                    $display("FAIL mon_stall_stable: got v=%b w=%h s=%b want v=1 w=%h s=%b",
                             out_valid, dout, out_sat, stall_word, stall_sat);
                end
            end
            if (!out_valid) begin
                checks++;
                if (dout !== 16'h0000 || out_sat !== 1'b0) begin
                    errors++;
                    $display("FAIL mon_idle_zero: got w=%h s=%b want w=0000 s=0", dout, out_sat);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL mon_unexpected: got w=%h want no word", dout);
                end else begin
                    m_e = sb.pop_front();
                    if (dout !== m_e.word || out_sat !== m_e.sat || $countones(dout) != m_e.kc) begin
                        errors++;
                        $display("FAIL mon_word: got w=%h s=%b ones=%0d want w=%h s=%b ones=%0d",
                                 dout, out_sat, $countones(dout), m_e.word, m_e.sat, m_e.kc);
                    end
                end
            end
            stall_q    = out_valid && !out_ready;
            stall_word = dout;
            stall_sat  = out_sat;
            if (in_valid && in_ready) begin
                m_kc = (input_a > 5'd16) ? 16 : int'(input_a);
                sb.push_back('{model_word(int'(input_a), m_rot), input_a > 5'd16, m_kc});
                m_acc++;
            end
            if (rot_clr)
                m_rot = 0;
            else if (in_valid && in_ready)
                m_rot = (m_rot + 1) % 16;
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic send(input logic [4:0] k);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        input_a  = k;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) begin
            errors++;
            checks++;
            $display("FAIL send_timeout: got no accept want accept for k=%0d", k);
        end
    endtask

    task automatic pop();
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || dout !== 16'h0 || out_sat !== 1'b0 || words_acc !== 16'h0) begin
            errors++;
            $display("FAIL reset_during: got v=%b r=%b w=%h s=%b acc=%h want 0 1 0000 0 0000",
                     out_valid, in_ready, dout, out_sat, words_acc);
        end
        do_reset();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || words_acc !== 16'h0) begin
            errors++;
            $display("FAIL reset_after: got v=%b r=%b acc=%h want 0 1 0000", out_valid, in_ready, words_acc);
        end
    endtask

    task automatic test_basic();
        do_reset();
        out_ready = 1'b0;
        send(5'd0);
        checks++;
        if (out_valid !== 1'b1 || dout !== 16'h0000 || out_sat !== 1'b0) begin
            errors++;
            $display("FAIL basic_k0: got v=%b w=%h s=%b want 1 0000 0", out_valid, dout, out_sat);
        end
        pop();
        send(5'd3);
        checks++;
        if (out_valid !== 1'b1 || dout !== 16'h000E || out_sat !== 1'b0) begin
            errors++;
            $display("FAIL basic_k3: got v=%b w=%h s=%b want 1 000e 0", out_valid, dout, out_sat);
        end
        pop();
    endtask

    task automatic test_wrap();
        do_reset();
        out_ready = 1'b1;
        repeat (14) send(5'd0);
        @(posedge clk);
        #1 out_ready = 1'b0;
        send(5'd4);
        checks++;
        if (dout !== 16'hC003) begin
            errors++;
            $display("FAIL wrap_rot14: got %h want c003", dout);
        end
        pop();
        send(5'd1);
        checks++;
        if (dout !== 16'h8000) begin
            errors++;
            $display("FAIL wrap_rot15: got %h want 8000", dout);
        end
        pop();
        send(5'd1);
        checks++;
        if (dout !== 16'h0001) begin
            errors++;
            $display("FAIL wrap_rot0: got %h want 0001", dout);
        end
        pop();
    endtask

    task automatic test_sat();
        do_reset();
        out_ready = 1'b0;
        send(5'd20);
        checks++;
        if (dout !== 16'hFFFF || out_sat !== 1'b1) begin
            errors++;
            $display("FAIL sat_k20: got w=%h s=%b want ffff 1", dout, out_sat);
        end
        pop();
        send(5'd16);
        checks++;
        if (dout !== 16'hFFFF || out_sat !== 1'b0) begin
            errors++;
            $display("FAIL sat_k16: got w=%h s=%b want ffff 0", dout, out_sat);
        end
        pop();
        send(5'd31);
        checks++;
        if (dout !== 16'hFFFF || out_sat !== 1'b1) begin
            errors++;
            $display("FAIL sat_k31: got w=%h s=%b want ffff 1", dout, out_sat);
        end
        pop();
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        input_a   = 5'd1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_rdy0: got %b want 1", in_ready);
        end
        @(posedge clk);
        #1 input_a = 5'd2;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_rdy1: got %b want 1", in_ready);
        end
        @(posedge clk);
        #1 input_a = 5'd3;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || dout !== 16'h0001) begin
                errors++;
                $display("FAIL b2b_full_hold: got r=%b v=%b w=%h want 0 1 0001", in_ready, out_valid, dout);
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (dout !== 16'h0006 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second: got w=%h r=%b want 0006 1", dout, in_ready);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || dout !== 16'h001C) begin
            errors++;
            $display("FAIL b2b_third: got v=%b w=%h want 1 001c", out_valid, dout);
        end
        @(posedge clk);
        #1 out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drained: got v=%b want 0", out_valid);
        end
    endtask

    task automatic test_rot_clr();
        do_reset();
        out_ready = 1'b1;
        repeat (7) send(5'd0);
        @(posedge clk);
        #1 out_ready = 1'b0;
        rot_clr = 1'b1;
        send(5'd2);
        rot_clr = 1'b0;
        checks++;
        if (dout !== 16'h0180) begin
            errors++;
            $display("FAIL rotclr_word: got %h want 0180", dout);
        end
        pop();
        send(5'd2);
        checks++;
        if (dout !== 16'h0003) begin
            errors++;
            $display("FAIL rotclr_next: got %h want 0003", dout);
        end
        pop();
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 1'b0;
        send(5'd1);
        send(5'd2);
        checks++;
        if (in_ready !== 1'b0 || words_acc !== 16'd2) begin
            errors++;
            $display("FAIL rstmid_pre: got r=%b acc=%h want 0 0002", in_ready, words_acc);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || words_acc !== 16'h0 || dout !== 16'h0) begin
            errors++;
            $display("FAIL rstmid_async: got v=%b r=%b acc=%h w=%h want 0 1 0000 0000",
                     out_valid, in_ready, words_acc, dout);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        send(5'd5);
        checks++;
        if (dout !== 16'h001F || words_acc !== 16'd1) begin
            errors++;
            $display("FAIL rstmid_after: got w=%h acc=%h want 001f 0001", dout, words_acc);
        end
        pop();
    endtask

    task automatic test_random();
        do_reset();
        repeat (400) begin
            in_valid  = 1'($urandom_range(0, 1));
            input_a   = 5'($urandom_range(0, 31));
            out_ready = 1'($urandom_range(0, 1));
            rot_clr   = ($urandom_range(0, 15) == 0);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        rot_clr   = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("FAIL random_drain: got v=%b left=%0d want 0 0", out_valid, sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_sat();
        test_back_to_back();
        test_rot_clr();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
